// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if
// Handshake and data bundle for the chunked multi-precision adder.
// The operand side uses valid/ready with in_valid/in_ready.
// The result side uses valid/ready with out_valid/out_ready.
//   in_valid, in_ready : operand handshake
//   a, b               : W-bit operands (W = N*K)
//   cin, sub           : carry-in for add; subtract select
//   out_valid, out_ready : result handshake
//   sum, cout, ovf     : W-bit result, carry out of MSB, signed overflow
// The slave modport is the adder side. The master modport is the
// producer/consumer side.
interface seq_chunk_adder_if #(
    parameter int N = 4,
    parameter int K = 4
) ();
    localparam int W = N * K;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
// This is a multi-cycle adder/subtractor for W = N*K bit operands.
// One N-bit ripple-carry slice is reused once per clock, starting with the least
// significant chunk. The carry out of each chunk is registered and becomes the
// carry into the next chunk.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : seq_chunk_adder_if.slave, which carries the operand handshake, the
//         result handshake, sum, cout and ovf
// Subtraction stores ~b and seeds the carry with 1, so the datapath always adds.

// rca_slice: N-bit gate-level ripple-carry adder.
//   a, b : N-bit addends   cin : carry in
//   sum  : N-bit sum       cout : carry out of the top bit
module rca_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        logic p;
        assign p        = a[i] ^ b[i];
        assign sum[i]   = p ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
    end

    assign cout = c[N];
endmodule

module seq_chunk_adder #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_chunk_adder_if.slave bus
);
    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          in_ready_c;

    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W-1:0]  sum_r;
    logic [IW-1:0] idx;
    logic          carry;
    logic          cout_r;
    logic          ovf_r;
    logic          out_valid_r;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;

    logic          accept;
    logic          consume;

    // The current chunk of each stored operand goes to the single shared slice.
    assign slice_a = opa[idx*N +: N];
    assign slice_b = opb[idx*N +: N];

    rca_slice #(.N(N)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign accept  = (state == IDLE) && bus.in_valid;
    assign consume = (state == DONE) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. in_ready is a pure decode of IDLE, so in DONE a new
    // operand cannot be accepted on the same edge as the result is consumed.
    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. The final chunk also captures cout and ovf.
    // In the ovf test, the new MSB of the sum comes straight from the slice,
    // because sum_r has not been updated yet on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa         <= '0;
            opb         <= '0;
            sum_r       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept) begin
            opa         <= bus.a;
            opb         <= bus.sub ? ~bus.b : bus.b;
            carry       <= bus.sub | bus.cin;
            idx         <= '0;
            out_valid_r <= 1'b0;
        end else if (state == RUN) begin
            sum_r[idx*N +: N] <= slice_sum;
            carry             <= slice_cout;
            if (idx == LAST) begin
                idx         <= '0;
                cout_r      <= slice_cout;
                ovf_r       <= (opa[W-1] == opb[W-1]) && (slice_sum[N-1] != opa[W-1]);
                out_valid_r <= 1'b1;
            end else begin
                idx <= idx + IW'(1);
            end
        end else if (consume) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder
// This bench drives two instances of seq_chunk_adder:
//   dut  : N=4,  K=4
//   dut1 : N=16, K=1
// The wide instance is checked every cycle against a transaction-level
// reference model. Directed vectors with literal expected values pin that model.
// The single-chunk instance is checked with directed literal vectors.
module tb_seq_chunk_adder;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_chunk_adder_if #(.N(N),  .K(K)) bus  ();
    seq_chunk_adder_if #(.N(16), .K(1)) bus1 ();

    seq_chunk_adder #(.N(N),  .K(K)) dut  (.clk(clk), .rst(rst), .bus(bus));
    seq_chunk_adder #(.N(16), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub,
                                     output logic [W-1:0] s, output logic c, output logic o);
        int         sa;
        int         sb;
        int         sr;
        logic [W:0] t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            s  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            s  = t[W-1:0];
            c  = t[W];
            sr = sa + sb + int'(cin);
        end
        o = (sr > 32767) || (sr < -32768);
    endfunction

    // Transaction model for the K=4 instance.
    // An accepted operand yields a result K edges later.
    // The result is held until it is consumed. The delivered result stays on
    // sum/cout/ovf until the next one replaces it or reset clears it.
    logic         m_armed = 1'b0;
    logic         m_busy  = 1'b0;
    logic         m_valid = 1'b0;
    int           m_edges = 0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    logic         m_ovf   = 1'b0;
    logic [W-1:0] r_sum   = '0;
    logic         r_cout  = 1'b0;
    logic         r_ovf   = 1'b0;

    always @(negedge clk) begin
        if (m_armed) begin
            checkOutput("model in_ready", bus.in_ready, !m_busy);
            checkOutput("model out_valid", bus.out_valid, m_valid);
            if (m_valid || !m_busy) begin
                checkOutput("model sum", bus.sum, m_sum);
                checkOutput("model cout", bus.cout, m_cout);
                checkOutput("model ovf", bus.ovf, m_ovf);
            end
        end
        if (rst) begin
            m_armed = 1'b1;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy  = 1'b1;
                m_edges = 0;
                refModel(bus.a, bus.b, bus.cin, bus.sub, r_sum, r_cout, r_ovf);
            end
        end else if (!m_valid) begin
            m_edges++;
            if (m_edges == K) begin
                m_valid = 1'b1;
                m_sum   = r_sum;
                m_cout  = r_cout;
                m_ovf   = r_ovf;
            end
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready timeout: got 0 expected 1");
        end
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(input string name);
        int edges;
        edges = 0;
        while (!bus.out_valid && edges < 50) begin
            tick();
            edges++;
        end
        checkOutput({name, " latency"}, edges, K);
    endtask

    task automatic checkResult(input string name, input logic [W-1:0] es,
                               input logic ec, input logic eo);
        checkOutput({name, " sum"}, bus.sum, es);
        checkOutput({name, " cout"}, bus.cout, ec);
        checkOutput({name, " ovf"}, bus.ovf, eo);
        checkOutput({name, " in_ready"}, bus.in_ready, 1'b0);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic runDirected(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub,
                               input logic [W-1:0] es, input logic ec, input logic eo);
        applyStimulus(a, b, cin, sub);
        waitResult(name);
        checkResult(name, es, ec, eo);
        consume();
    endtask

    task automatic runK1(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!bus1.in_ready && n < 20) begin
            tick();
            n++;
        end
        bus1.a        = a;
        bus1.b        = b;
        bus1.cin      = cin;
        bus1.sub      = sub;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        tick();
        checkOutput({name, " out_valid"}, bus1.out_valid, 1'b1);
        checkOutput({name, " sum"}, bus1.sum, es);
        checkOutput({name, " cout"}, bus1.cout, ec);
        checkOutput({name, " ovf"}, bus1.ovf, eo);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        checkOutput({name, " in_ready after"}, bus1.in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.cin        = 1'b0;
        bus.sub        = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.cin       = 1'b0;
        bus1.sub       = 1'b0;
        bus1.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset in_ready", bus.in_ready, 1'b1);
        checkOutput("reset out_valid", bus.out_valid, 1'b0);
        checkOutput("reset sum", bus.sum, 16'h0000);
        checkOutput("reset cout", bus.cout, 1'b0);
        checkOutput("reset ovf", bus.ovf, 1'b0);

        runDirected("add basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        runDirected("add ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runDirected("add cin ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        runDirected("add ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runDirected("sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        runDirected("sub borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Backpressure: new operands wait while the result sits in DONE.
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        waitResult("bp first");
        bus.a        = 16'h0102;
        bus.b        = 16'h0304;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp hold out_valid", bus.out_valid, 1'b1);
            checkOutput("bp hold sum", bus.sum, 16'h2345);
            checkOutput("bp hold in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("bp release out_valid", bus.out_valid, 1'b0);
        checkOutput("bp release in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        waitResult("bp second");
        checkResult("bp second", 16'h0406, 1'b0, 1'b0);
        consume();

        // Reset while the third chunk is about to be processed.
        applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst run out_valid", bus.out_valid, 1'b0);
        checkOutput("rst run sum", bus.sum, 16'h0000);
        checkOutput("rst run in_ready", bus.in_ready, 1'b1);
        repeat (8) tick();
        checkOutput("rst run no result", bus.out_valid, 1'b0);

        // Reset while a result is waiting in DONE.
        applyStimulus(16'h8001, 16'h8001, 1'b0, 1'b0);
        waitResult("rst done");
        checkResult("rst done", 16'h0002, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst done out_valid", bus.out_valid, 1'b0);
        checkOutput("rst done sum", bus.sum, 16'h0000);
        checkOutput("rst done cout", bus.cout, 1'b0);
        checkOutput("rst done ovf", bus.ovf, 1'b0);
        checkOutput("rst done in_ready", bus.in_ready, 1'b1);

        // Random traffic. out_ready is toggled during RUN, where it must be
        // ignored, and the consumer stalls for a random time in DONE.
        for (int t = 0; t < 200; t++) begin
            ra = $urandom();
            rb = $urandom();
            applyStimulus(ra[15:0], rb[15:0], ra[16], rb[16]);
            bus.out_ready = rb[17];
            waitResult("random");
            bus.out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            consume();
            if ($urandom_range(0, 1) == 1) tick();
        end

        runK1("k1 ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runK1("k1 ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runK1("k1 sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
